// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory address/data, redirect request and IF/ID slot to decode.
// Latency: none, wires only.
// Backpressure: decode stalls the slot through out_ready; the master modport belongs to the fetch unit.
interface pc_fetch_unit_if;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;
    logic        fault;

    modport master (
        output pc,
        input  instr_in,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output halted,
        output fault
    );

    modport slave (
        input  pc,
        output instr_in,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, captures instr_in into a registered IF/ID slot, handles redirect/halt/fault.
// Latency: an instruction shows up on out_* one cycle after the edge where its pc is presented; 1/cycle.
// Backpressure: out_valid && !out_ready holds pc and slot; optional FETCH_PERF_EN adds fetch/stall counters.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] PC_STEP    = 32'd4,
    parameter logic [31:0] IMEM_DEPTH = 32'd64
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.master fetch
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] pc_q;
    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_instr_q;

    logic        running;
    logic        pc_ok;
    logic        slot_free;
    logic        do_redirect;
    logic        do_fault;
    logic        do_halt;
    logic        do_capture;
    logic        handshake;
    logic        stalled;

    // Decode this cycle's action; redirect outranks everything, then fault, halt, capture.
    always_comb begin
        running     = (state == RUN);
        pc_ok       = (pc_q < IMEM_DEPTH) && (pc_q[1:0] == 2'b00);
        slot_free   = !out_valid_q || fetch.out_ready;
        handshake   = running && out_valid_q && fetch.out_ready;
        stalled     = running && out_valid_q && !fetch.out_ready && !fetch.redirect_valid;
        do_redirect = running && fetch.redirect_valid;
        do_fault    = running && !fetch.redirect_valid && slot_free && !pc_ok;
        do_halt     = running && !fetch.redirect_valid && slot_free && pc_ok
                      && (fetch.instr_in == 32'h0);
        do_capture  = running && !fetch.redirect_valid && slot_free && pc_ok
                      && (fetch.instr_in != 32'h0);
    end

    // State register; HALT and FAULT only leave through reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (do_fault) begin
                    next_state = FAULT;
                end else if (do_halt) begin
                    next_state = HALT;
                end
            end
            HALT:    next_state = HALT;
            FAULT:   next_state = FAULT;
            default: next_state = FAULT;
        endcase
    end

    // PC and IF/ID slot; the slot keeps its last pc/instr when flushed or stopped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= 32'h0;
        end else if (do_redirect) begin
            pc_q        <= fetch.redirect_target;
            out_valid_q <= 1'b0;
        end else if (do_fault || do_halt || !running) begin
            out_valid_q <= 1'b0;
        end else if (do_capture) begin
            out_pc_q    <= pc_q;
            out_instr_q <= fetch.instr_in;
            out_valid_q <= 1'b1;
            pc_q        <= pc_q + PC_STEP;
        end
    end

    // Outputs: halted/fault are decoded straight from the terminal states, so they are sticky.
    always_comb begin
        fetch.pc        = pc_q;
        fetch.out_valid = out_valid_q;
        fetch.out_pc    = out_pc_q;
        fetch.out_instr = out_instr_q;
        fetch.halted    = (state != RUN);
        fetch.fault     = (state == FAULT);
    end

`ifdef FETCH_PERF_EN
    // Performance counters; they stop moving once fetch has stopped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stalled) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized redirect/backpressure traffic.
// Latency: expectations updated once per clock by an in-bench program-level model.
// Backpressure: out_ready driven by the bench, both directed and random.
module tb_pc_fetch_unit;

    logic clk;
    logic reset;

    pc_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    pc_fetch_unit #(
        .RESET_PC   (32'd0),
        .PC_STEP    (32'd4),
        .IMEM_DEPTH (32'd64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-word instruction memory, byte-addressed by pc; anything past it reads junk.
    logic [31:0] mem [16];
    assign bus.instr_in = (bus.pc < 32'd64) ? mem[bus.pc[5:2]] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: program counter, one-entry slot, and a stopped/faulted flag.
    logic [31:0] m_pc;
    bit          m_vld;
    logic [31:0] m_opc;
    logic [31:0] m_oinstr;
    bit          m_stopped;
    bit          m_fault;
    int unsigned m_fetches;
    int unsigned m_stalls;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        if (addr < 64) return mem[addr / 4];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic model_step(input bit rst_n, input bit rv, input logic [31:0] rt, input bit rdy);
        logic [31:0] w;
        if (!rst_n) begin
            m_pc = 0; m_vld = 0; m_opc = 0; m_oinstr = 0;
            m_stopped = 0; m_fault = 0; m_fetches = 0; m_stalls = 0;
            return;
        end
        if (m_stopped) return;
        if (m_vld && rdy) m_fetches++;
        if (m_vld && !rdy && !rv) m_stalls++;
        if (rv) begin
            m_pc  = rt;
            m_vld = 0;
        end else if (!m_vld || rdy) begin
            w = word_at(m_pc);
            if (m_pc >= 64 || (m_pc % 4) != 0) begin
                m_stopped = 1; m_fault = 1; m_vld = 0;
            end else if (w == 0) begin
                m_stopped = 1; m_vld = 0;
            end else begin
                m_opc = m_pc; m_oinstr = w; m_vld = 1;
                m_pc  = m_pc + 4;
            end
        end
    endtask

    task automatic compare_model();
        check("pc", bus.pc, m_pc);
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_vld});
        check("out_pc", bus.out_pc, m_opc);
        check("out_instr", bus.out_instr, m_oinstr);
        check("halted", {31'd0, bus.halted}, {31'd0, m_stopped});
        check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, m_fetches);
        check("stall_count", stall_count, m_stalls);
`endif
    endtask

    // One clock: drive inputs, advance model, sample the DUT 1 ns after the edge.
    task automatic cycle(input bit rst_n, input bit rv, input logic [31:0] rt, input bit rdy);
        reset               = rst_n;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.out_ready       = rdy;
        model_step(rst_n, rv, rt, rdy);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic fill_mem_nonzero();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0101 * (i + 1);
    endtask

    initial begin
        reset               = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.out_ready       = 1'b0;
        fill_mem_nonzero();
        mem[4] = 32'h0;
        @(negedge clk);

        // Sequential run ending on a null word at 16.
        cycle(0, 0, 0, 1);
        check("rst_pc", bus.pc, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 1);
            check("seq_out_pc", bus.out_pc, 32'(4 * i));
            check("seq_valid", {31'd0, bus.out_valid}, 32'd1);
            check("seq_instr", bus.out_instr, 32'h0000_0101 * 32'(i + 1));
        end
        cycle(1, 0, 0, 1);
        check("halt_valid", {31'd0, bus.out_valid}, 32'd0);
        check("halt_halted", {31'd0, bus.halted}, 32'd1);
        check("halt_fault", {31'd0, bus.fault}, 32'd0);
        check("halt_pc", bus.pc, 32'd16);

        // Back-pressure: hold slot 0 for three cycles, then drain with no bubble.
        fill_mem_nonzero();
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("bp_first_pc", bus.out_pc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0);
            check("bp_hold_out_pc", bus.out_pc, 32'd0);
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_pc", bus.pc, 32'd4);
        end
        cycle(1, 0, 0, 1);
        check("bp_release_out_pc", bus.out_pc, 32'd4);
        check("bp_release_valid", {31'd0, bus.out_valid}, 32'd1);
`ifdef FETCH_PERF_EN
        check("perf_stall", stall_count, 32'd3);
        check("perf_fetch", fetch_count, 32'd1);
`endif

        // Redirect to 40 while slot 8 is stalled.
        cycle(1, 0, 0, 1);
        check("rd_pre_out_pc", bus.out_pc, 32'd8);
        cycle(1, 1, 32'd40, 0);
        check("rd_flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rd_pc", bus.pc, 32'd40);
        cycle(1, 0, 0, 1);
        check("rd_out_pc", bus.out_pc, 32'd40);
        check("rd_out_instr", bus.out_instr, 32'h0000_0101 * 32'd11);

        // Misaligned redirect target faults one cycle later; later redirects are ignored.
        cycle(1, 1, 32'd42, 1);
        check("mis_no_fault_yet", {31'd0, bus.fault}, 32'd0);
        cycle(1, 0, 0, 1);
        check("mis_fault", {31'd0, bus.fault}, 32'd1);
        check("mis_halted", {31'd0, bus.halted}, 32'd1);
        check("mis_valid", {31'd0, bus.out_valid}, 32'd0);
        cycle(1, 1, 32'd0, 1);
        check("mis_redirect_ignored", bus.pc, 32'd42);
        check("mis_fault_sticky", {31'd0, bus.fault}, 32'd1);

        // Run off the end of memory.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1);
        check("end_last_out_pc", bus.out_pc, 32'd60);
        cycle(1, 0, 0, 1);
        check("end_fault", {31'd0, bus.fault}, 32'd1);
        check("end_pc", bus.pc, 32'd64);

        // Reset in the middle of a stall, with a redirect pending.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
        check("ms_stalled", {31'd0, bus.out_valid}, 32'd1);
        cycle(0, 1, 32'd40, 0);
        check("ms_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ms_pc", bus.pc, 32'd0);
        check("ms_halted", {31'd0, bus.halted}, 32'd0);
        check("ms_fault", {31'd0, bus.fault}, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          rst_n;
            bit          rv;
            bit          rdy;
            logic [31:0] rt;
            rst_n = !(($urandom_range(0, 99) == 0) || (m_stopped && $urandom_range(0, 3) == 0));
            if (!rst_n) begin
                for (int i = 0; i < 16; i++)
                    mem[i] = ($urandom_range(0, 24) == 0) ? 32'h0 : ($urandom | 32'h1);
            end
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 15))
                0:       rt = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                1:       rt = 32'(64 + 4 * $urandom_range(0, 8));
                default: rt = 32'(4 * $urandom_range(0, 15));
            endcase
            cycle(rst_n, rv, rt, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
